// File: rtl/logic_axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and protection attributes.
package logic_axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef struct packed {
    logic instruction;
    logic non_secure;
    logic privileged;
  } prot_t;

endpackage

// File: rtl/logic_axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. Once raised, valid and its payload stay
// put until that transfer; ready may be raised or dropped at any time.
interface logic_axi4_lite_if #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 16
);
  import logic_axi4_lite_pkg::*;

  logic [ADDRESS_WIDTH-1:0]  awaddr;
  prot_t                     awprot;
  logic                      awvalid;
  logic                      awready;
  logic [8*DATA_BYTES-1:0]   wdata;
  logic [DATA_BYTES-1:0]     wstrb;
  logic                      wvalid;
  logic                      wready;
  resp_t                     bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  prot_t                     arprot;
  logic                      arvalid;
  logic                      arready;
  logic [8*DATA_BYTES-1:0]   rdata;
  resp_t                     rresp;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/logic_axi4_lite_write_regs_timeout.sv
// Watchdog for a pending register write. Counts cycles spent waiting for an
// ack and flags expiry in the TIMEOUT-th waiting cycle.
module logic_axi4_lite_write_regs_timeout #(
  parameter int TIMEOUT = 256
) (
  input  logic aclk,
  input  logic areset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int COUNT_BITS = $clog2(TIMEOUT + 1);

  logic [COUNT_BITS-1:0] count;

  // Restart on every new request, advance once per waiting cycle
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + COUNT_BITS'(1);
    end
  end

  assign expired = enable && (count == COUNT_BITS'(TIMEOUT - 1));

endmodule

// File: rtl/logic_axi4_lite_write_regs.sv
// AXI4-Lite write terminator: turns each aligned AW+W pair into one
// register-bus write with ack handshake, then returns a B response.
// One transaction in flight; the read channels are tied off.
// Optional request watchdog: define LOGIC_AXI4_LITE_WRITE_REGS_TIMEOUT_EN.
module logic_axi4_lite_write_regs
  import logic_axi4_lite_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int REGISTERS     = 64,
  parameter int TIMEOUT       = 256
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  logic_axi4_lite_if.slave              slave,
  output logic                          reg_write,
  output logic [$clog2(REGISTERS)-1:0]  reg_address,
  output logic [8*DATA_BYTES-1:0]       reg_wdata,
  output logic [DATA_BYTES-1:0]         reg_wstrb,
  input  logic                          reg_ack,
  input  logic                          reg_error,
  output logic [1:0]                    state_debug
);

  localparam int OFFSET_BITS = $clog2(DATA_BYTES);
  localparam int INDEX_BITS  = $clog2(REGISTERS);
  localparam logic [ADDRESS_WIDTH:0] ADDRESS_LIMIT =
    (ADDRESS_WIDTH + 1)'(REGISTERS * DATA_BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    RESPONSE = 2'd2
  } state_t;

  state_t state;
  logic   bvalid_q;
  resp_t  bresp_q;
  logic   accept;
  logic   in_range;
  logic   request_done;
  logic   request_error;

  // AW and W are only ever taken together, and only when idle
  assign accept   = (state == IDLE) && slave.awvalid && slave.wvalid;
  assign in_range = {1'b0, slave.awaddr} < ADDRESS_LIMIT;

`ifdef LOGIC_AXI4_LITE_WRITE_REGS_TIMEOUT_EN
  logic expired;

  logic_axi4_lite_write_regs_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clear    (accept && in_range),
    .enable   (state == REQUEST),
    .expired  (expired)
  );

  // A real ack in the expiry cycle takes priority over the watchdog
  assign request_done  = reg_ack || expired;
  assign request_error = reg_ack ? reg_error : 1'b1;
`else
  localparam int unused_timeout = TIMEOUT;

  assign request_done  = reg_ack;
  assign request_error = reg_error;
`endif

  // Control FSM with registered reg_write and B-channel outputs
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      reg_write <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              state     <= REQUEST;
              reg_write <= 1'b1;
            end else begin
              state    <= RESPONSE;
              bvalid_q <= 1'b1;
              bresp_q  <= DECERR;
            end
          end
        end
        REQUEST: begin
          if (request_done) begin
            state     <= RESPONSE;
            reg_write <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= request_error ? SLVERR : OKAY;
          end
        end
        RESPONSE: begin
          if (slave.bready) begin
            state    <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          reg_write <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Capture the request payload on accept; held steady until the next accept
  always_ff @(posedge aclk) begin
    if (accept) begin
      reg_address <= slave.awaddr[OFFSET_BITS +: INDEX_BITS];
      reg_wdata   <= slave.wdata;
      reg_wstrb   <= slave.wstrb;
    end
  end

  assign slave.awready = accept;
  assign slave.wready  = accept;
  assign slave.bvalid  = bvalid_q;
  assign slave.bresp   = bresp_q;

  assign slave.arready = 1'b0;
  assign slave.rvalid  = 1'b0;
  assign slave.rdata   = '0;
  assign slave.rresp   = OKAY;

  assign state_debug = state;

  // Protection bits, read channel inputs and address bits outside the word
  // index carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{slave.awprot, slave.awaddr, slave.araddr,
                           slave.arprot, slave.arvalid, slave.rready};

endmodule

// File: tb/tb_logic_axi4_lite_write_regs.sv
// Bench for logic_axi4_lite_write_regs: directed cases plus randomized
// writes checked against a transaction-level model of the write path.
module tb_logic_axi4_lite_write_regs;
  import logic_axi4_lite_pkg::*;

  localparam int DB    = 4;
  localparam int AW    = 16;
  localparam int REGS  = 64;
  localparam int TO    = 8;
  localparam int IDX_W = $clog2(REGS);
  localparam int EXP_W = IDX_W + 8 * DB + DB;

  // ---------------- clock / reset ----------------
  logic aclk;
  logic areset_n;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  logic_axi4_lite_if #(.DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) axi ();

  logic                 reg_write;
  logic [IDX_W-1:0]     reg_address;
  logic [8*DB-1:0]      reg_wdata;
  logic [DB-1:0]        reg_wstrb;
  logic                 reg_ack;
  logic                 reg_error;
  logic [1:0]           state_debug;

  logic_axi4_lite_write_regs #(
    .DATA_BYTES    (DB),
    .ADDRESS_WIDTH (AW),
    .REGISTERS     (REGS),
    .TIMEOUT       (TO)
  ) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .slave       (axi),
    .reg_write   (reg_write),
    .reg_address (reg_address),
    .reg_wdata   (reg_wdata),
    .reg_wstrb   (reg_wstrb),
    .reg_ack     (reg_ack),
    .reg_error   (reg_error),
    .state_debug (state_debug)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic resp_t model_resp(input int unsigned addr, input int ack_wait, input bit err);
    if (addr >= REGS * DB) return DECERR;
`ifdef LOGIC_AXI4_LITE_WRITE_REGS_TIMEOUT_EN
    if (ack_wait >= TO) return SLVERR;
`endif
    return err ? SLVERR : OKAY;
  endfunction

  // Number of cycles reg_write is expected high for an in-range write
  function automatic int model_hi_cycles(input int ack_wait);
`ifdef LOGIC_AXI4_LITE_WRITE_REGS_TIMEOUT_EN
    if (ack_wait >= TO) return TO;
`endif
    return ack_wait + 1;
  endfunction

  // ---------------- driver ----------------
  // Full write: optional half-valid pre-phase, accept, register wait with ack
  // after ack_wait cycles, then B response held for bready_wait cycles.
  task automatic axi_write(input int unsigned addr, input logic [31:0] data, input logic [3:0] strb,
                           input int ack_wait, input bit err, input int bready_wait,
                           input int pre, input bit pre_aw);
    bit               in_range;
    int               hi_cycles;
    resp_t            exp_resp;
    logic [EXP_W-1:0] exp;
    in_range  = addr < REGS * DB;
    exp_resp  = model_resp(addr, ack_wait, err);
    hi_cycles = in_range ? model_hi_cycles(ack_wait) : 0;
    exp       = '0;
    if (in_range) exp_q.push_back({IDX_W'(addr / DB), data, strb});

    axi.awaddr = AW'(addr);
    axi.wdata  = data;
    axi.wstrb  = strb;
    axi.awprot = prot_t'(3'($urandom_range(0, 7)));
    for (int i = 0; i < pre; i++) begin
      axi.awvalid = pre_aw;
      axi.wvalid  = !pre_aw;
      @(negedge aclk);
      check("half_valid_awready", 64'(axi.awready), 64'(0));
      check("half_valid_wready", 64'(axi.wready), 64'(0));
      @(posedge aclk); #1;
    end

    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    @(negedge aclk);
    check("accept_awready", 64'(axi.awready), 64'(1));
    check("accept_wready", 64'(axi.wready), 64'(1));
    @(posedge aclk); #1;

    if (in_range && exp_q.size() > 0) exp = exp_q.pop_front();
    for (int k = 0; k < hi_cycles; k++) begin
      axi.awvalid = 1'($urandom_range(0, 1));
      axi.wvalid  = axi.awvalid;
      axi.awaddr  = AW'($urandom_range(0, 255));
      reg_ack     = (k == ack_wait);
      reg_error   = (k == ack_wait) ? err : 1'($urandom_range(0, 1));
      @(negedge aclk);
      check("req_reg_write", 64'(reg_write), 64'(1));
      check("req_awready", 64'(axi.awready), 64'(0));
      check("req_fields", 64'({reg_address, reg_wdata, reg_wstrb}), 64'(exp));
      @(posedge aclk); #1;
    end

    for (int k = 0; k <= bready_wait; k++) begin
      axi.bready  = (k == bready_wait);
      axi.awvalid = (k < bready_wait) && 1'($urandom_range(0, 1));
      axi.wvalid  = axi.awvalid;
      reg_ack     = 1'($urandom_range(0, 1));
      reg_error   = 1'($urandom_range(0, 1));
      @(negedge aclk);
      check("resp_bvalid", 64'(axi.bvalid), 64'(1));
      check("resp_bresp", 64'(axi.bresp), 64'(exp_resp));
      check("resp_reg_write", 64'(reg_write), 64'(0));
      check("resp_awready", 64'(axi.awready), 64'(0));
      @(posedge aclk); #1;
    end
    axi.bready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    reg_ack     = 1'b0;
    reg_error   = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned addr;
    int          max_wait;
    areset_n    = 1'b0;
    axi.awaddr  = '0;
    axi.awprot  = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.araddr  = '0;
    axi.arprot  = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    reg_ack     = 1'b0;
    reg_error   = 1'b0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 64'(axi.awready), 64'(0));
    check("rst_wready", 64'(axi.wready), 64'(0));
    check("rst_bvalid", 64'(axi.bvalid), 64'(0));
    check("rst_bresp", 64'(axi.bresp), 64'(OKAY));
    check("rst_reg_write", 64'(reg_write), 64'(0));
    check("rst_state", 64'(state_debug), 64'(0));
    check("rst_arready", 64'(axi.arready), 64'(0));
    check("rst_rvalid", 64'(axi.rvalid), 64'(0));
    @(posedge aclk); #1;
    areset_n = 1'b1;

    // Directed cases
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0, 0, 1'b0);
    axi_write(32'h100, 32'h12345678, 4'hF, 0, 1'b0, 0, 0, 1'b0);
    axi_write(32'hFF, 32'hA5A5A5A5, 4'h0, 0, 1'b0, 0, 0, 1'b0);
    axi_write(32'h14, 32'hCAFEF00D, 4'h3, 5, 1'b1, 0, 0, 1'b0);
    axi_write(32'h20, 32'h0BADC0DE, 4'h9, 1, 1'b0, 10, 0, 1'b0);
    axi_write(32'h33, 32'h11223344, 4'hC, 0, 1'b0, 0, 4, 1'b1);
    axi_write(32'h4, 32'h55667788, 4'h1, 2, 1'b0, 1, 3, 1'b0);

    // Randomized writes
`ifdef LOGIC_AXI4_LITE_WRITE_REGS_TIMEOUT_EN
    max_wait = TO + 2;
`else
    max_wait = 6;
`endif
    for (int n = 0; n < 30; n++) begin
      addr = ($urandom_range(0, 4) == 0) ? $urandom_range(REGS * DB, 16'hFFFF)
                                         : $urandom_range(0, REGS * DB - 1);
      axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, max_wait),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    // Reset while a register write is pending
    axi.awaddr  = AW'(16'h10);
    axi.wdata   = 32'h01020304;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    @(negedge aclk);
    check("midrst_pre_reg_write", 64'(reg_write), 64'(1));
    #2 areset_n = 1'b0;
    #1;
    check("midrst_reg_write", 64'(reg_write), 64'(0));
    check("midrst_state", 64'(state_debug), 64'(0));
    check("midrst_bvalid", 64'(axi.bvalid), 64'(0));
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    axi.bready = 1'b1;
    reg_ack    = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      check("postrst_bvalid", 64'(axi.bvalid), 64'(0));
      check("postrst_reg_write", 64'(reg_write), 64'(0));
    end
    @(posedge aclk); #1;
    axi.bready = 1'b0;
    reg_ack    = 1'b0;

`ifdef LOGIC_AXI4_LITE_WRITE_REGS_TIMEOUT_EN
    // Ack never arrives, ack exactly in the expiry cycle (clean and error)
    axi_write(32'h24, 32'hFEEDFACE, 4'hF, TO + 20, 1'b0, 0, 0, 1'b0);
    axi_write(32'h28, 32'h13579BDF, 4'hF, TO - 1, 1'b0, 0, 0, 1'b0);
    axi_write(32'h2C, 32'h2468ACE0, 4'hF, TO - 1, 1'b1, 0, 0, 1'b0);
`endif

    // Recovery after reset
    axi_write(32'hFC, 32'h89ABCDEF, 4'h6, 0, 1'b0, 0, 0, 1'b0);

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
